instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 154 +++++++++++++++
 tb/tb_instr_fetch.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC, single-outstanding imem requests, instruction buffer
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_stall counters.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] encoded_value,
  output logic [31:0] instr_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic        fetch_fault
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_KILL,
    S_HALT
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic           fault_q, fault_d;

  logic [31:0]    buf_data [FIFO_DEPTH];
  logic [31:0]    buf_pc   [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;

  logic fifo_empty, fifo_full;
  logic req_fire, push, pop;
  logic outstanding_after;
  logic redirect_misaligned;

  assign fifo_empty          = (count == '0);
  assign fifo_full           = (count == CW'(FIFO_DEPTH));
  assign req_fire            = imem_req_valid && imem_req_ready;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

  // Only WAIT delivers into the buffer; a redirect kills the response landing with it.
  assign push = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    fault_d           = fault_q;
    imem_req_valid    = 1'b0;
    outstanding_after = 1'b0;

    case (state_q)
      S_FETCH: begin
        // Buffer has no outstanding slot here, so only the stored count gates a request.
        imem_req_valid = !rst && !fifo_full;
        if (req_fire) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) state_d = S_FETCH;
      end
      S_KILL: begin
        if (imem_rsp_valid) state_d = fault_q ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      fault_d = redirect_misaligned;
      // A response arriving with the redirect is the stale one, so nothing stays in flight.
      outstanding_after = req_fire ||
                          (((state_q == S_WAIT) || (state_q == S_KILL)) && !imem_rsp_valid);
      if (outstanding_after)        state_d = S_KILL;
      else if (redirect_misaligned) state_d = S_HALT;
      else                          state_d = S_FETCH;
    end
  end

  assign imem_req_addr = pc_q;
  assign fetch_fault   = fault_q;

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= imem_rsp_data;
      buf_pc[wr_ptr]   <= pc_q - 32'd4;
    end
  end

  assign instr_valid   = !fifo_empty;
  assign encoded_value = fifo_empty ? 32'd0 : buf_data[rd_ptr];
  assign instr_pc      = fifo_empty ? 32'd0 : buf_pc[rd_ptr];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (fifo_empty && (state_q != S_HALT)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with a latency-configurable memory model
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] encoded_value;
  logic [31:0] instr_pc;
  logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];

  int          lat = 1;
  bit          mem_pending = 0;
  logic [31:0] mem_paddr = '0;
  int          mem_cnt = 0;

  instr_fetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .encoded_value  (encoded_value),
    .instr_pc       (instr_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
`endif
    .fetch_fault    (fetch_fault)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Memory: returns addr+1 'lat' cycles after acceptance.
  always @(negedge clk) begin
    if (rst) begin
      mem_pending    = 0;
      imem_rsp_valid = 0;
    end else begin
      imem_rsp_valid = 0;
      if (mem_pending) begin
        if (mem_cnt <= 1) begin
          imem_rsp_valid = 1;
          imem_rsp_data  = mem_paddr + 32'd1;
          mem_pending    = 0;
        end else begin
          mem_cnt = mem_cnt - 1;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (mem_pending || imem_req_addr[1:0] != 2'b00) begin
          errors++;
          $display("FAIL req_protocol: addr=%h pending=%0d, required aligned with none outstanding",
                   imem_req_addr, mem_pending);
        end
        mem_pending = 1;
        mem_paddr   = imem_req_addr;
        mem_cnt     = lat;
        req_log.push_back(imem_req_addr);
      end
    end
  end

  // Scoreboard: every pop is compared against the next expected PC.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && !redirect_valid && instr_valid && instr_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (instr_pc !== e || encoded_value !== e + 32'd1) begin
        errors++;
        $display("FAIL stream: got pc=%h data=%h, required pc=%h data=%h",
                 instr_pc, encoded_value, e, e + 32'd1);
      end
    end
  end

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d entries left, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_outstanding(input logic [31:0] a, input bit any, input string name);
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_pending && (any || mem_paddr == a)) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_outstanding: not seen, required request %h outstanding", name, a);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0 ||
        encoded_value !== 32'd0 || instr_pc !== 32'd0) begin
      errors++;
      $display("FAIL %s_outputs: req=%b iv=%b fault=%b data=%h pc=%h, required all 0",
               name, imem_req_valid, instr_valid, fetch_fault, encoded_value, instr_pc);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
      errors++;
      $display("FAIL %s_perf: fetched=%0d stall=%0d, required 0 0", name, perf_fetched, perf_stall);
    end
`endif
  endtask

  task automatic apply_reset();
    rst = 1;
    redirect_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    req_log.delete();
    rst = 0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1;
    redirect_pc    = pc;
    exp_q.delete();
    @(posedge clk); #1;
    redirect_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    exp_q.delete();
    req_log.delete();
    rst = 0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL reset_first_req: valid=%b addr=%h, required 1 00000100", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_basic();
    lat = 1;
    instr_ready = 1;
    push_exp(32'h100, 3);
    wait_drain("basic");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= req_log.size() || req_log[i] !== 32'h100 + 32'(4 * i)) begin
        errors++;
        $display("FAIL basic_req%0d: got %h, required %h", i,
                 (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx, 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    lat = 1;
    instr_ready = 0;
    apply_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || req_log.size() != 2) begin
      errors++;
      $display("FAIL full_stall: req_valid=%b requests=%0d, required 0 and 2", imem_req_valid, req_log.size());
    end
    checks++;
    if (instr_valid !== 1'b1 || encoded_value !== 32'h101 || instr_pc !== 32'h100) begin
      errors++;
      $display("FAIL full_head: iv=%b data=%h pc=%h, required 1 00000101 00000100",
               instr_valid, encoded_value, instr_pc);
    end
    @(posedge clk); #1;
    push_exp(32'h100, 4);
    instr_ready = 1;
    wait_drain("backpressure");
  endtask

  task automatic test_redirect_outstanding();
    lat = 3;
    instr_ready = 1;
    apply_reset();
    wait_outstanding(32'h10C, 0, "redirect");
    do_redirect(32'h2000);
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_flush: instr_valid=%b, required 0", instr_valid);
    end
    push_exp(32'h2000, 3);
    wait_drain("redirect");
  endtask

  task automatic test_fault();
    int n0;
    bit req_seen = 0;
    do_redirect(32'h2002);
    n0 = req_log.size();
    @(negedge clk);
    checks++;
    if (fetch_fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_set: fetch_fault=%b, required 1", fetch_fault);
    end
    repeat (8) begin
      @(negedge clk);
      if (imem_req_valid !== 1'b0) req_seen = 1;
    end
    checks++;
    if (req_seen || req_log.size() != n0 || instr_valid !== 1'b0 || fetch_fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_halt: req_seen=%0d new_reqs=%0d iv=%b fault=%b, required 0 0 0 1",
               req_seen, req_log.size() - n0, instr_valid, fetch_fault);
    end
    @(posedge clk); #1;
    lat = 1;
    do_redirect(32'h3000);
    @(negedge clk);
    checks++;
    if (fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: fetch_fault=%b, required 0", fetch_fault);
    end
    push_exp(32'h3000, 2);
    wait_drain("fault");
  endtask

  task automatic test_wrap();
    lat = 1;
    do_redirect(32'hFFFF_FFF8);
    push_exp(32'hFFFF_FFF8, 3);
    wait_drain("wrap");
  endtask

  task automatic test_reset_mid();
    lat = 3;
    wait_outstanding(32'h0, 1, "reset_mid");
    rst = 1;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    @(posedge clk); #1;
    exp_q.delete();
    req_log.delete();
    rst = 0;
    lat = 1;
    push_exp(32'h100, 2);
    wait_drain("reset_mid");
    checks++;
    if (req_log.size() == 0 || req_log[0] !== 32'h100) begin
      errors++;
      $display("FAIL reset_mid_first_req: got %h, required 00000100",
               (req_log.size() != 0) ? req_log[0] : 32'hxxxx_xxxx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    rst            = 1;
    imem_req_ready = 1;
    imem_rsp_valid = 0;
    imem_rsp_data  = 0;
    redirect_valid = 0;
    redirect_pc    = 0;
    instr_ready    = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_outstanding();
    test_fault();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
